// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file port arbiter.
//   state_t   : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   REQ_A/B   : requester IDs, also used as the round-robin pointer value
//   other_req : returns the opposite requester ID
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic other_req(input logic id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   i_req_a, i_req_b : request lines
//   i_ptr            : requester favoured when both request
//   o_valid          : at least one request present
//   o_id             : winning requester ID (REQ_A / REQ_B)
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_ptr,
  output logic o_valid,
  output logic o_id
);

  // Pick the lone requester, or the favoured one on contention.
  always_comb begin
    o_valid = i_req_a | i_req_b;
    o_id    = REQ_A;
    if (i_req_a && i_req_b) begin
      o_id = i_ptr;
    end else if (i_req_b) begin
      o_id = REQ_B;
    end else begin
      o_id = REQ_A;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single port of a register file between requesters A and B.
// Each granted request is one register-file access: IDLE -> ACCESS -> RESP.
//   In_Clock_50MHz, In_Reset_n         : clock, synchronous active-low reset
//   In_Req*/In_Write*/In_Address*/In_WriteData* : requester A/B command
//   Out_DoneA/Out_DoneB                : one-cycle completion pulses
//   Out_ReadData                       : read result, valid with Done of a read
//   Out_Busy                           : high while not IDLE
//   Out_RF_*, In_RF_ReadData           : register-file pins
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int P_RegWidth = 3,
  parameter int P_BitWidth = 32
) (
  input  logic                  In_Clock_50MHz,
  input  logic                  In_Reset_n,
  input  logic                  In_ReqA,
  input  logic                  In_WriteA,
  input  logic [P_RegWidth-1:0] In_AddressA,
  input  logic [P_BitWidth-1:0] In_WriteDataA,
  input  logic                  In_ReqB,
  input  logic                  In_WriteB,
  input  logic [P_RegWidth-1:0] In_AddressB,
  input  logic [P_BitWidth-1:0] In_WriteDataB,
  output logic                  Out_DoneA,
  output logic                  Out_DoneB,
  output logic [P_BitWidth-1:0] Out_ReadData,
  output logic                  Out_Busy,
  output logic [P_RegWidth-1:0] Out_RF_Address,
  output logic [P_BitWidth-1:0] Out_RF_WriteData,
  output logic                  Out_RF_Write,
  output logic                  Out_RF_Read,
  input  logic [P_BitWidth-1:0] In_RF_ReadData
);

  state_t                r_state;
  logic                  r_ptr;
  logic                  r_id;
  logic                  r_wr;
  logic [P_RegWidth-1:0] r_addr;
  logic [P_BitWidth-1:0] r_wdata;
  logic                  r_done_a;
  logic                  r_done_b;
  logic [P_BitWidth-1:0] r_read_data;

  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_access;
  logic                  w_sel_wr;
  logic [P_RegWidth-1:0] w_sel_addr;
  logic [P_BitWidth-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .i_req_a (In_ReqA),
    .i_req_b (In_ReqB),
    .i_ptr   (r_ptr),
    .o_valid (w_grant_valid),
    .o_id    (w_grant_id)
  );

  // Command fields of whichever requester the picker chose.
  assign w_sel_wr    = (w_grant_id == REQ_B) ? In_WriteB     : In_WriteA;
  assign w_sel_addr  = (w_grant_id == REQ_B) ? In_AddressB   : In_AddressA;
  assign w_sel_wdata = (w_grant_id == REQ_B) ? In_WriteDataB : In_WriteDataA;

  // Arbiter FSM with latched command, pointer and registered responses.
  always_ff @(posedge In_Clock_50MHz) begin
    if (!In_Reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= REQ_A;
      r_id        <= REQ_A;
      r_wr        <= 1'b0;
      r_addr      <= {P_RegWidth{1'b0}};
      r_wdata     <= {P_BitWidth{1'b0}};
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_read_data <= {P_BitWidth{1'b0}};
    end else begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_id    <= w_grant_id;
            r_wr    <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= S_ACCESS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // Writes leave the previous read result visible.
          if (!r_wr) begin
            r_read_data <= In_RF_ReadData;
          end else begin
            r_read_data <= r_read_data;
          end
          // Setting Done here makes it high exactly during RESP.
          r_done_a <= (r_id == REQ_A);
          r_done_b <= (r_id == REQ_B);
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_ptr   <= other_req(r_id);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_access = (r_state == S_ACCESS);

  // Strobes are gated with reset so an access coinciding with reset never lands.
  assign Out_RF_Address   = w_access ? r_addr  : {P_RegWidth{1'b0}};
  assign Out_RF_WriteData = w_access ? r_wdata : {P_BitWidth{1'b0}};
  assign Out_RF_Write     = w_access & r_wr  & In_Reset_n;
  assign Out_RF_Read      = w_access & ~r_wr & In_Reset_n;

  assign Out_DoneA    = r_done_a;
  assign Out_DoneB    = r_done_b;
  assign Out_ReadData = r_read_data;
  assign Out_Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with an attached register-file model.
module tb_regfile_port_arbiter;

  localparam int RW = 3;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, wr_a, req_b, wr_b;
  logic [RW-1:0] addr_a, addr_b;
  logic [BW-1:0] wd_a, wd_b;
  logic          done_a, done_b, busy, rf_wr, rf_rd;
  logic [BW-1:0] rdata, rf_wdata, rf_rdata;
  logic [RW-1:0] rf_addr;

  logic [BW-1:0] mem [8] = '{default: 32'h0};
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          id;
    logic          rd;
    logic [BW-1:0] data;
    int            cyc;
  } done_t;

  typedef struct {
    logic          wr;
    logic [RW-1:0] addr;
    logic [BW-1:0] data;
  } rf_t;

  done_t done_q[$];
  rf_t   rf_q[$];

  regfile_port_arbiter #(.P_RegWidth(RW), .P_BitWidth(BW)) dut (
    .In_Clock_50MHz   (clk),
    .In_Reset_n       (rst_n),
    .In_ReqA          (req_a),
    .In_WriteA        (wr_a),
    .In_AddressA      (addr_a),
    .In_WriteDataA    (wd_a),
    .In_ReqB          (req_b),
    .In_WriteB        (wr_b),
    .In_AddressB      (addr_b),
    .In_WriteDataB    (wd_b),
    .Out_DoneA        (done_a),
    .Out_DoneB        (done_b),
    .Out_ReadData     (rdata),
    .Out_Busy         (busy),
    .Out_RF_Address   (rf_addr),
    .Out_RF_WriteData (rf_wdata),
    .Out_RF_Write     (rf_wr),
    .Out_RF_Read      (rf_rd),
    .In_RF_ReadData   (rf_rdata)
  );

  always #10 clk = ~clk;

  // cycle index: value during the period that follows each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // register file model: asynchronous read, write on rising edge
  always @(posedge clk) if (rf_wr) mem[rf_addr] <= rf_wdata;
  assign rf_rdata = mem[rf_addr];

  task automatic check(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // completion monitor
  initial forever begin
    @(negedge clk);
    if (done_a || done_b) begin
      done_t e;
      check("done_exclusive", {31'd0, done_a & done_b}, 32'd0);
      if (done_q.size() == 0) begin
        check("done_unexpected", {30'd0, done_b, done_a}, 32'd0);
      end else begin
        e = done_q.pop_front();
        check("done_id", {31'd0, done_b}, {31'd0, e.id});
        check("done_cycle", cyc, e.cyc);
        if (e.rd) check("read_data", rdata, e.data);
      end
    end
  end

  // register-file port monitor
  initial forever begin
    @(negedge clk);
    if (rf_wr || rf_rd) begin
      rf_t e;
      if (rf_q.size() == 0) begin
        check("rf_unexpected", {30'd0, rf_rd, rf_wr}, 32'd0);
      end else begin
        e = rf_q.pop_front();
        check("rf_write_flag", {31'd0, rf_wr}, {31'd0, e.wr});
        check("rf_read_flag", {31'd0, rf_rd}, {31'd0, ~e.wr});
        check("rf_address", {29'd0, rf_addr}, {29'd0, e.addr});
        if (e.wr) check("rf_wdata", rf_wdata, e.data);
      end
    end else if (rst_n) begin
      check("rf_idle_addr", {29'd0, rf_addr}, 32'd0);
      check("rf_idle_wdata", rf_wdata, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic id, input logic wr, input logic [RW-1:0] a, input logic [BW-1:0] d);
    if (id) begin
      req_b = 1'b1; wr_b = wr; addr_b = a; wd_b = d;
    end else begin
      req_a = 1'b1; wr_a = wr; addr_a = a; wd_a = d;
    end
  endtask

  // one isolated transaction; Done is expected two cycles after issue
  task automatic do_txn(input logic id, input logic wr, input logic [RW-1:0] a,
                        input logic [BW-1:0] d, input logic [BW-1:0] exp_rd);
    int c;
    c = cyc;
    set_cmd(id, wr, a, d);
    done_q.push_back('{id: id, rd: ~wr, data: exp_rd, cyc: c + 2});
    rf_q.push_back('{wr: wr, addr: a, data: d});
    tick(2);
    req_a = 1'b0;
    req_b = 1'b0;
    tick(2);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    req_a = 1'b0; wr_a = 1'b0; addr_a = 3'd0; wd_a = 32'd0;
    req_b = 1'b0; wr_b = 1'b0; addr_b = 3'd0; wd_b = 32'd0;
    tick(3);

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {30'd0, done_b, done_a}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rf_strobes", {30'd0, rf_rd, rf_wr}, 32'd0);
    rst_n = 1'b1;

    // A writes DEADBEEF to reg 5, then B reads it back
    do_txn(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
    check("mem5_written", mem[5], 32'hDEAD_BEEF);
    do_txn(1'b1, 1'b0, 3'd5, 32'd0, 32'hDEAD_BEEF);

    // both requesters held high from reset: grants A, B, A, B
    rst_n = 1'b0;
    set_cmd(1'b0, 1'b1, 3'd1, 32'h0000_0011);
    set_cmd(1'b1, 1'b1, 3'd2, 32'h0000_0022);
    tick(2);
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      logic id;
      id = (i % 2 == 1);
      done_q.push_back('{id: id, rd: 1'b0, data: 32'd0, cyc: c + 2 + 3 * i});
      rf_q.push_back('{wr: 1'b1, addr: id ? 3'd2 : 3'd1, data: id ? 32'h22 : 32'h11});
    end
    rst_n = 1'b1;
    tick(11);
    req_a = 1'b0;
    req_b = 1'b0;
    tick(2);
    check("mem1", mem[1], 32'h11);
    check("mem2", mem[2], 32'h22);

    // B alone, Req held: three reads at k+2, k+5, k+8
    c = cyc;
    set_cmd(1'b1, 1'b0, 3'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      done_q.push_back('{id: 1'b1, rd: 1'b1, data: 32'h22, cyc: c + 2 + 3 * i});
      rf_q.push_back('{wr: 1'b0, addr: 3'd2, data: 32'd0});
    end
    tick(8);
    req_b = 1'b0;
    tick(2);

    // reset lands during ACCESS of an A write to reg 3
    set_cmd(1'b0, 1'b1, 3'd3, 32'hBAD0_0003);
    tick(1);
    check("access_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    check("rst_gates_write", {31'd0, rf_wr}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    tick(3);
    check("mem3_untouched", mem[3], 32'd0);

    // boundary addresses 0 and 7
    do_txn(1'b0, 1'b1, 3'd0, 32'h0123_4567, 32'd0);
    do_txn(1'b1, 1'b1, 3'd7, 32'hA5A5_5A5A, 32'd0);
    do_txn(1'b0, 1'b0, 3'd7, 32'd0, 32'hA5A5_5A5A);
    do_txn(1'b1, 1'b0, 3'd0, 32'd0, 32'h0123_4567);
    // a write keeps the previous read result
    do_txn(1'b0, 1'b1, 3'd1, 32'h0000_0077, 32'd0);
    check("rdata_held", rdata, 32'h0123_4567);
    check("mem0", mem[0], 32'h0123_4567);
    check("mem7", mem[7], 32'hA5A5_5A5A);

    tick(4);
    check("done_q_drained", done_q.size(), 32'd0);
    check("rf_q_drained", rf_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
